// File: rtl/keyword_lexer_pkg.sv
// Shared definitions for the keyword lexer: token kinds, FSM state encoding
// and the default delimiter.
package keyword_lexer_pkg;

  localparam logic [1:0] TOK_NONE  = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  localparam logic [1:0] TOK_WORD  = 2'd3;

  localparam logic [7:0] DELIM_DEFAULT = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_B1   = 4'd1,
    ST_B2   = 4'd2,
    ST_B3   = 4'd3,
    ST_B4   = 4'd4,
    ST_BK   = 4'd5,
    ST_E1   = 4'd6,
    ST_E2   = 4'd7,
    ST_EK   = 4'd8,
    ST_WORD = 4'd9
  } state_e;

  // Token classification of a word that ends while the FSM sits in state s.
  function automatic logic [1:0] kind_of(state_e s);
    case (s)
      ST_BK:   kind_of = TOK_BEGIN;
      ST_EK:   kind_of = TOK_END;
      default: kind_of = TOK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/keyword_lexer_char_fold.sv
// Combinational ASCII fold: maps A-Z to a-z, passes every other byte unchanged.
module char_fold (
  input  logic [7:0] ch_i,
  output logic [7:0] ch_o
);

  always_comb begin
    ch_o = ch_i;
    if (ch_i >= 8'h41 && ch_i <= 8'h5A) ch_o = ch_i | 8'h20;
  end

endmodule

// File: rtl/keyword_lexer.sv
// Splits a byte stream into space-delimited words and classifies each as
// BEGIN, END or WORD. Define KEYWORD_LEXER_CASE_SENSITIVE_EN to disable case folding.
module keyword_lexer
  import keyword_lexer_pkg::*;
#(
  parameter int         LEN_W = 8,
  parameter logic [7:0] DELIM = DELIM_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  input  logic             in_last,
  output logic             tok_valid,
  output logic [1:0]       tok_kind,
  output logic [LEN_W-1:0] tok_len,
  output logic             done
);

  logic [7:0]       ch;
  logic             is_delim;
  state_e           state_q, state_d, adv_st;
  logic [LEN_W-1:0] len_q, len_d, len_inc;

  logic             tok_valid_q, tok_valid_d;
  logic [1:0]       tok_kind_q, tok_kind_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             done_q, done_d;

`ifdef KEYWORD_LEXER_CASE_SENSITIVE_EN
  assign ch = in;
`else
  char_fold u_fold (.ch_i(in), .ch_o(ch));
`endif

  assign is_delim = (ch == DELIM);
  assign len_inc  = (&len_q) ? len_q : len_q + {{(LEN_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_kind_q  <= TOK_NONE;
      tok_len_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tok_valid_q <= tok_valid_d;
      tok_kind_q  <= tok_kind_d;
      tok_len_q   <= tok_len_d;
      done_q      <= done_d;
    end
  end

  // State reached by a non-delimiter char; any off-keyword char lands in WORD.
  always_comb begin
    adv_st = ST_WORD;
    case (state_q)
      ST_IDLE: if (ch == "b") adv_st = ST_B1; else if (ch == "e") adv_st = ST_E1;
      ST_B1:   if (ch == "e") adv_st = ST_B2;
      ST_B2:   if (ch == "g") adv_st = ST_B3;
      ST_B3:   if (ch == "i") adv_st = ST_B4;
      ST_B4:   if (ch == "n") adv_st = ST_BK;
      ST_E1:   if (ch == "n") adv_st = ST_E2;
      ST_E2:   if (ch == "d") adv_st = ST_EK;
      default: adv_st = ST_WORD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (in_valid) begin
      if (is_delim || in_last) begin
        state_d = ST_IDLE;
        len_d   = '0;
      end else begin
        state_d = adv_st;
        len_d   = len_inc;
      end
    end
  end

  // in_last on a letter consumes it first, so the token uses adv_st and len_inc.
  always_comb begin
    tok_valid_d = 1'b0;
    tok_kind_d  = TOK_NONE;
    tok_len_d   = '0;
    done_d      = 1'b0;
    if (in_valid) begin
      done_d = in_last;
      if (is_delim) begin
        if (state_q != ST_IDLE) begin
          tok_valid_d = 1'b1;
          tok_kind_d  = kind_of(state_q);
          tok_len_d   = len_q;
        end
      end else if (in_last) begin
        tok_valid_d = 1'b1;
        tok_kind_d  = kind_of(adv_st);
        tok_len_d   = len_inc;
      end
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_kind  = tok_kind_q;
  assign tok_len   = tok_len_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keyword_lexer.sv
// Self-checking bench for keyword_lexer: fixed vector table, directed streams
// and random streams against a word-level reference model.
module tb_keyword_lexer;
  import keyword_lexer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_c = 8'h00;
  logic       in_last = 1'b0;
  logic       tok_valid;
  logic [1:0] tok_kind;
  logic [7:0] tok_len;
  logic       done;

  always #5 clk = ~clk;

  keyword_lexer #(.LEN_W(8), .DELIM(8'h20)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_c), .in_last(in_last),
    .tok_valid(tok_valid), .tok_kind(tok_kind), .tok_len(tok_len), .done(done)
  );

  typedef struct packed {
    logic       tv;
    logic [1:0] kind;
    logic [7:0] len;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic       last;
    exp_t       e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the pending word as a list of characters plus its length.
  byte unsigned wq[$];
  int           wn = 0;

  function automatic byte unsigned mfold(byte unsigned c);
`ifdef KEYWORD_LEXER_CASE_SENSITIVE_EN
    return c;
`else
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
    return c;
`endif
  endfunction

  function automatic logic word_is(string kw);
    if (wn != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++)
      if (wq[i] != kw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(logic v, byte unsigned c, logic last);
    exp_t        e;
    byte unsigned fc;
    e = '0;
    if (!v) return e;
    fc = mfold(c);
    if (fc != 8'h20) begin
      wn++;
      if (wq.size() < 8) wq.push_back(fc);
    end
    if (fc == 8'h20 || last) begin
      if (wn > 0) begin
        e.tv   = 1'b1;
        e.kind = word_is("begin") ? TOK_BEGIN : (word_is("end") ? TOK_END : TOK_WORD);
        e.len  = (wn > 255) ? 8'd255 : 8'(wn);
      end
      e.done = last;
      wq.delete();
      wn = 0;
    end
    return e;
  endfunction

  task automatic check(exp_t e, string name);
    n_vec++;
    if (tok_valid !== e.tv || tok_kind !== e.kind || tok_len !== e.len || done !== e.done) begin
      n_err++;
      $display("FAIL %s: got tv=%0b kind=%0d len=%0d done=%0b, want tv=%0b kind=%0d len=%0d done=%0b",
               name, tok_valid, tok_kind, tok_len, done, e.tv, e.kind, e.len, e.done);
    end
  endtask

  task automatic step(logic v, byte unsigned c, logic last, string name);
    exp_t e;
    in_valid = v;
    in_c     = c;
    in_last  = last;
    e = model(v, c, last);
    @(posedge clk);
    #1;
    check(e, name);
  endtask

  task automatic send_str(string s, logic last_at_end, string name);
    for (int i = 0; i < s.len(); i++)
      step(1'b1, s[i], last_at_end && (i == s.len() - 1), name);
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock.
  task automatic async_reset(string name);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check('0, name);
    wq.delete();
    wn = 0;
    @(posedge clk);
    #1;
    check('0, {name, "_hold"});
    reset = 1'b1;
  endtask

  vec_t  tbl[9];
  string s0;

  initial begin
    // Fixed table: "begin end" with in_last on 'd'.
    s0 = "begin end";
    for (int i = 0; i < 9; i++) begin
      tbl[i].v    = 1'b1;
      tbl[i].c    = s0[i];
      tbl[i].last = (i == 8);
      tbl[i].e    = '0;
    end
    tbl[5].e = '{tv: 1'b1, kind: TOK_BEGIN, len: 8'd5, done: 1'b0};
    tbl[8].e = '{tv: 1'b1, kind: TOK_END,   len: 8'd3, done: 1'b1};

    reset = 1'b0;
    #1;
    check('0, "reset_state");
    repeat (2) @(posedge clk);
    #1;
    check('0, "reset_held");
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      exp_t dummy;
      in_valid = tbl[i].v;
      in_c     = tbl[i].c;
      in_last  = tbl[i].last;
      dummy = model(tbl[i].v, tbl[i].c, tbl[i].last);
      @(posedge clk);
      #1;
      check(tbl[i].e, "tbl_begin_end");
    end

    step(1'b0, 8'h20, 1'b0, "idle_gap");

    send_str("BeGiN x ", 1'b1, "mixed_case");
    send_str("beginx endd xend ", 1'b1, "near_keywords");
    send_str("xbegin begins", 1'b1, "midword_kw");

    // Alternating valid gaps; garbage on the bus during gaps must be ignored.
    s0 = "  a   b ";
    for (int i = 0; i < s0.len(); i++) begin
      step(1'b0, 8'h20, 1'b1, "gap");
      step(1'b1, s0[i], 1'b0, "toggle_valid");
    end

    step(1'b1, 8'h20, 1'b1, "idle_last");

    for (int i = 0; i < 300; i++) step(1'b1, "a", 1'b0, "sat_fill");
    step(1'b1, 8'h20, 1'b0, "sat_tok");

    send_str("zz ", 1'b0, "pre_reset_tok");
    async_reset("rst_tok_clear");
    send_str("begi", 1'b0, "pending_begi");
    async_reset("rst_mid_word");
    send_str(" end ", 1'b0, "post_reset_end");

    begin
      string alpha;
      alpha = "begindBEGINDx  ";
      for (int i = 0; i < 600; i++)
        step(($urandom_range(0, 3) != 0), alpha[$urandom_range(0, alpha.len() - 1)],
             ($urandom_range(0, 29) == 0), "random");
    end
    step(1'b1, 8'h20, 1'b1, "random_flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keyword_lexer.md
Name: keyword_lexer

Overview:
Upstream lexer stage for the block-matching checker. Consumes a byte stream, one character per valid cycle, and splits it into space-delimited words. For each word it emits one classified token: BEGIN, END or WORD. The downstream checker then works on token events instead of raw characters, so it no longer needs per-character keyword tracking.

Parameters:
LEN_W, 8, width of tok_len; the word-length counter saturates at 2^LEN_W-1
DELIM, 8'h20, delimiter character (space)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; the block is in reset while reset==0
in_valid  input  1  in/in_last are sampled only when 1
in  input  8  ASCII character
in_last  input  1  marks the final character of the stream; qualified by in_valid
tok_valid  output  1  one-cycle pulse: token fields are valid
tok_kind  output  2  0=NONE, 1=BEGIN, 2=END, 3=WORD
tok_len  output  LEN_W  character count of the emitted word, saturating
done  output  1  one-cycle pulse: stream end processed

Behaviour:
- Reset (reset==0, async): state=IDLE; len counter=0; tok_valid=0; tok_kind=NONE; tok_len=0; done=0. A partially matched word is discarded and no token is emitted.
- All outputs are registered. A token appears exactly 1 cycle after the accepted input that terminated the word.
- When in_valid==0: state and counter hold; tok_valid=0; done=0. Idle cycles never terminate a word.
- Character folding: A-Z is mapped to a-z before matching. Non-letters are never mapped to a letter.
- FSM states: IDLE, B1(b), B2(be), B3(beg), B4(begi), BK(begin), E1(e), E2(en), EK(end), WORD.
  - From IDLE: 'b'->B1; 'e'->E1; DELIM->IDLE; any other char->WORD.
  - Along the chain b-e-g-i-n and e-n-d: the expected next char advances one state. Any other non-delimiter char goes to WORD.
  - From BK or EK: a non-delimiter char goes to WORD. Example: "begins" and "endx" are WORDs.
  - WORD: stays in WORD until a delimiter arrives.
  - A keyword match never starts mid-word. Example: "xbegin" is a WORD.
- Word termination: an accepted DELIM in any non-IDLE state. The next cycle gives tok_valid=1; tok_kind is BEGIN if the state was BK, END if EK, otherwise WORD. State returns to IDLE.
- Length: the counter increments on each accepted non-delimiter char and saturates at all-ones. tok_len is the counter value including the terminating-cycle char. The counter clears when a token is emitted.
- Consecutive or leading delimiters produce no tokens.
- in_last handling (in_valid==1):
  - Non-delimiter char: the char is consumed, then the pending word is terminated in the same step. The next cycle has tok_valid=1 and done=1 together.
  - Delimiter: terminates any pending word as above, with done=1 in the same cycle as the token.
  - State is IDLE and char is a delimiter: done=1 with tok_valid=0 and tok_kind=NONE.
  - After in_last the FSM is IDLE and accepts a new stream on the next cycle.
- tok_kind=NONE and tok_len=0 whenever tok_valid==0.

Optional Feature:
Macro KEYWORD_LEXER_CASE_SENSITIVE_EN.
- Defined: folding is disabled. Only lowercase "begin"/"end" classify as BEGIN/END; "BEGIN" or "End" yield WORD.
- Undefined (default): matching is case-insensitive as described above.
- Port list and timing are identical in both builds.

Decomposition:
- Package keyword_lexer_pkg holds:
  - tok_kind localparams TOK_NONE/TOK_BEGIN/TOK_END/TOK_WORD (2-bit).
  - FSM state encodings (4-bit, 10 states).
  - DELIM default.
- One natural sub-module: char_fold, a combinational 8-bit lowercase fold. It is instantiated once and bypassed under KEYWORD_LEXER_CASE_SENSITIVE_EN.
- The FSM, length counter and output registers stay in keyword_lexer.

Test Plan:
- Stream "begin end" + in_last on 'd' -> tok (BEGIN,5) one cycle after the space; tok (END,3) together with done=1 one cycle after 'd'.
- Stream "BeGiN x" then in_last on a space -> default build: (BEGIN,5), (WORD,1) with done=1. With KEYWORD_LEXER_CASE_SENSITIVE_EN: first token is (WORD,5).
- "beginx endd xend " (last space with in_last) -> three WORD tokens with lengths 6, 4, 4; no BEGIN/END; done on the third.
- "  a   b " with in_valid toggled 0/1 every other cycle -> exactly two (WORD,1) tokens. tok_valid never asserts during in_valid==0 gaps or on repeated spaces.
- 300 'a' chars then a space -> single (WORD,255) token, showing saturation at LEN_W=8.
- Drive "begi", then pull reset low mid-cycle (asynchronously), release, send " end " -> no token for "begi", outputs 0 immediately on reset assertion, then one (END,3) token.
